// File: rtl/fp32_max_reduce.sv
// rtl/fp32_max_reduce.sv - streaming IEEE-754 binary32 maximum reduction over a job of len elements
//
// fp32_naive_compare: returns the larger of two binary32 values by sign/pattern rules;
//    a NaN loses to any number, and two NaNs return a.
//    a, b   : operands
//    y      : selected operand
//
// fp32_max_reduce: accepts a job (start + len), consumes len beats on the input
//    stream, then presents the maximum until the consumer takes it.
//    clk, rst_n          : clock, asynchronous active-low reset
//    start, len          : job request and element count, sampled in IDLE
//    busy                : high whenever a job is in progress or a result is pending
//    in_valid/in_data    : element stream, accepted while in_ready is high
//    in_ready            : high while accumulating
//    out_valid/out_ready : result handshake
//    out_data            : registered maximum
//    out_all_nan         : every element was NaN, or the job was empty

module fp32_naive_compare (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic w_a_nan;
   logic w_b_nan;

   assign w_a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign w_b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

   always_comb begin
      y = a;
      if (w_a_nan && w_b_nan) begin
         y = a;
      end else if (w_a_nan) begin
         y = b;
      end else if (w_b_nan) begin
         y = a;
      end else if (a[31] != b[31]) begin
         // +0 beats -0 here as well, since only the sign is examined
         y = a[31] ? b : a;
      end else if (!a[31]) begin
         y = (b > a) ? b : a;
      end else begin
         // negative magnitudes grow with the pattern, so the smaller pattern is larger
         y = (b < a) ? b : a;
      end
   end
endmodule

module fp32_max_reduce #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_data,
   output logic             out_all_nan,
   input  logic             out_ready
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC00000;
   localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic [LEN_W-1:0] r_cnt;
   logic [31:0]      r_acc;
   logic             r_first;
   logic             r_any_num;
   logic [31:0]      r_out_data;
   logic             r_out_all_nan;

   logic             w_beat;
   logic             w_last;
   logic             w_job_start;
   logic             w_in_nan;
   logic [31:0]      w_max;
   logic [31:0]      w_new_acc;

   fp32_naive_compare u_cmp (
      .a (r_acc),
      .b (in_data),
      .y (w_max)
   );

   assign w_in_nan    = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
   assign w_beat      = in_valid && (r_state == S_ACCUM);
   assign w_last      = w_beat && (r_cnt == ONE);
   assign w_job_start = start && (r_state == S_IDLE);
   // The first beat of a job seeds the accumulator regardless of its value
   assign w_new_acc   = r_first ? in_data : w_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      busy      = (r_state != S_IDLE);
      in_ready  = (r_state == S_ACCUM);
      out_valid = (r_state == S_DONE);
      case (r_state)
         S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_ACCUM;
         S_ACCUM: if (w_last) w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_acc         <= 32'h0;
         r_first       <= 1'b0;
         r_any_num     <= 1'b0;
         r_out_data    <= 32'h0;
         r_out_all_nan <= 1'b0;
      end else if (w_job_start) begin
         r_any_num <= 1'b0;
         if (len == '0) begin
            r_out_data    <= QNAN;
            r_out_all_nan <= 1'b1;
         end else begin
            r_cnt   <= len;
            r_first <= 1'b1;
         end
      end else if (w_beat) begin
         r_acc     <= w_new_acc;
         r_first   <= 1'b0;
         r_any_num <= r_any_num | ~w_in_nan;
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE;
         end
         if (w_last) begin
            r_out_data    <= w_new_acc;
            r_out_all_nan <= ~(r_any_num | ~w_in_nan);
         end
      end
   end

   assign out_data    = r_out_data;
   assign out_all_nan = r_out_all_nan;
endmodule

// File: tb/tb_fp32_max_reduce.sv
// tb/tb_fp32_max_reduce.sv - directed self-checking bench for fp32_max_reduce

module tb_fp32_max_reduce;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        busy;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_all_nan;
   logic        out_ready;

   int vecs = 0;
   int errs = 0;

   fp32_max_reduce #(.LEN_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .len         (len),
      .busy        (busy),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_all_nan (out_all_nan),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic result(input string tag, input logic [31:0] d, input logic nan);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, out_data, d);
      check({tag, "_allnan"}, {31'd0, out_all_nan}, {31'd0, nan});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = 8'd0;
      in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_all_nan", {31'd0, out_all_nan}, 32'd0);
      rst_n = 1'b1;
      tick();

      // len=4, continuous beats: out_valid at cycle 5 after start
      start_job(8'd4);
      check("j1_busy", {31'd0, busy}, 32'd1);
      check("j1_in_ready", {31'd0, in_ready}, 32'd1);
      beat(32'h3F800000);
      beat(32'hC0000000);
      beat(32'h40400000);
      check("j1_not_yet", {31'd0, out_valid}, 32'd0);
      beat(32'h00000000);
      check("j1_in_ready_low", {31'd0, in_ready}, 32'd0);
      result("j1", 32'h40400000, 1'b0);

      // NaNs lose to numbers
      start_job(8'd3);
      beat(32'h7FC00000);
      beat(32'hBF800000);
      beat(32'h7FC00001);
      result("j2", 32'hBF800000, 1'b0);

      // all NaN keeps the first
      start_job(8'd2);
      beat(32'h7FC00000);
      beat(32'h7F800001);
      result("j3", 32'h7FC00000, 1'b1);

      // empty job goes straight to DONE
      start_job(8'd0);
      result("j4", 32'h7FC00000, 1'b1);

      // +0 beats -0
      start_job(8'd2);
      beat(32'h80000000);
      beat(32'h00000000);
      result("j5", 32'h00000000, 1'b0);

      // negatives: -0.5 is the largest of -1, -2, -0.5
      start_job(8'd3);
      beat(32'hBF800000);
      beat(32'hC0000000);
      beat(32'hBF000000);
      result("j6", 32'hBF000000, 1'b0);

      // +inf beats max finite
      start_job(8'd2);
      beat(32'h7F7FFFFF);
      beat(32'h7F800000);
      result("j7", 32'h7F800000, 1'b0);

      // stalls, ignored starts, output held while out_ready low
      start_job(8'd3);
      beat(32'h40000000);
      start = 1'b1; len = 8'd5;
      tick();
      start = 1'b0;
      check("j8_stall_busy", {31'd0, busy}, 32'd1);
      check("j8_stall_ready", {31'd0, in_ready}, 32'd1);
      beat(32'h3F800000);
      tick();
      beat(32'h40800000);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1; len = 8'd2;
         in_valid = 1'b1; in_data = 32'h7F000000;
         check("j8_hold_valid", {31'd0, out_valid}, 32'd1);
         check("j8_hold_data", out_data, 32'h40800000);
         check("j8_hold_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      check("j8_data", out_data, 32'h40800000);
      out_ready = 1'b1; start = 1'b1; len = 8'd2;
      tick();
      out_ready = 1'b0; start = 1'b0;
      check("j8_drop", {31'd0, out_valid}, 32'd0);
      check("j8_start_ignored", {31'd0, busy}, 32'd0);
      tick();
      check("j8_still_idle", {31'd0, busy}, 32'd0);

      // async reset mid-job
      start_job(8'd4);
      beat(32'h3F800000);
      beat(32'h40000000);
      #2 rst_n = 1'b0;
      #1;
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_in_ready", {31'd0, in_ready}, 32'd0);
      check("ar_out_valid", {31'd0, out_valid}, 32'd0);
      check("ar_out_data", out_data, 32'h0);
      check("ar_all_nan", {31'd0, out_all_nan}, 32'd0);
      #1 rst_n = 1'b1;
      start_job(8'd1);
      check("j9_busy", {31'd0, busy}, 32'd1);
      beat(32'hFF800000);
      result("j9", 32'hFF800000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
